// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: FSM state encoding, range limits for an
// N-bit two's complement word, and sign/magnitude helpers.
package fxp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN,
    ST_DONE
  } fxp_state_e;

  // Largest positive value of an n-bit signed word.
  function automatic longint fxp_max_pos(input int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  // Most negative value of an n-bit signed word.
  function automatic longint fxp_min_neg(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

  function automatic longint fxp_abs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint fxp_neg(input longint v);
    return -v;
  endfunction

endpackage

// File: rtl/fxp_udiv_core.sv
// Unsigned iterative restoring divider: one quotient bit per cycle, MSB first.
// 'done' is high in the cycle the final quotient bit is being produced.
module fxp_udiv_core #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);
  import fxp_pkg::*;

  localparam int CW = $clog2(DW + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[DW-1]};
    trial   = shifted - (VW+2)'(dvs_q);
    done    = busy_q && (cnt_q == CW'(DW - 1));

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      // Dividend bits shift out of the top while quotient bits fill the bottom.
      if (shifted >= (VW+2)'(dvs_q)) begin
        rem_d = (VW+1)'(trial);
        quo_d = {quo_q[DW-2:0], 1'b1};
      end else begin
        rem_d = (VW+1)'(shifted);
        quo_d = {quo_q[DW-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/fxp_div.sv
// Signed Q(N-F).F divider with valid/ready handshake: sign-magnitude split,
// unsigned restoring core, then half-away-from-zero rounding and saturation.
module fxp_div #(
  parameter int N = 8,
  parameter int F = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         sat,
  output logic         div_by_zero
);
  import fxp_pkg::*;

  localparam int DW = N + F + 1;
  localparam logic [N-1:0]  Y_MAX   = N'(fxp_max_pos(N));
  localparam logic [N-1:0]  Y_MIN   = N'(fxp_min_neg(N));
  localparam logic [DW-1:0] LIM_POS = DW'(fxp_max_pos(N));
  localparam logic [DW-1:0] LIM_NEG = DW'(fxp_abs(fxp_min_neg(N)));

  fxp_state_e    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  y_q, y_d;
  logic          sat_q, sat_d;
  logic          dz_q, dz_d;
  logic          neg_q, neg_d;
  logic          a_neg_q, a_neg_d;
  logic          b_zero_q, b_zero_d;

  logic          core_start;
  logic          core_done;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [DW-1:0] dividend;
  logic [DW-1:0] quotient;
  logic [DW:0]   q_inc;
  logic [DW-1:0] mag;

  // N bits suffice for the magnitude: |-2^(N-1)| is exact as an unsigned value.
  assign a_mag    = N'(fxp_abs(longint'($signed(a))));
  assign b_mag    = N'(fxp_abs(longint'($signed(b))));
  assign dividend = DW'(a_mag) << (F + 1);

  // The core's extra LSB is the half bit, so (Q + 1) >> 1 rounds half away.
  assign q_inc = {1'b0, quotient} + (DW+1)'(1);
  assign mag   = DW'(q_inc >> 1);

  fxp_udiv_core #(
    .DW(DW),
    .VW(N)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .dividend(dividend),
    .divisor (b_mag),
    .done    (core_done),
    .quotient(quotient)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    sat_d       = sat_q;
    dz_d        = dz_q;
    neg_d       = neg_q;
    a_neg_d     = a_neg_q;
    b_zero_d    = b_zero_q;
    core_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          core_start = 1'b1;
          neg_d      = a[N-1] ^ b[N-1];
          a_neg_d    = a[N-1];
          b_zero_d   = (b == '0);
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (core_done) state_d = ST_FIN;
      end
      ST_FIN: begin
        if (b_zero_q) begin
          dz_d  = 1'b1;
          sat_d = 1'b1;
          y_d   = a_neg_q ? Y_MIN : Y_MAX;
        end else if (!neg_q) begin
          dz_d  = 1'b0;
          sat_d = (mag > LIM_POS);
          y_d   = (mag > LIM_POS) ? Y_MAX : N'(mag);
        end else begin
          // A zero magnitude negates to zero, so no negative zero can appear.
          dz_d  = 1'b0;
          sat_d = (mag > LIM_NEG);
          y_d   = (mag > LIM_NEG) ? Y_MIN : N'(fxp_neg(longint'(mag)));
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      dz_q        <= 1'b0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      b_zero_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      dz_q        <= dz_d;
      neg_q       <= neg_d;
      a_neg_q     <= a_neg_d;
      b_zero_q    <= b_zero_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign y           = y_q;
  assign sat         = sat_q;
  assign div_by_zero = dz_q;

endmodule
